ber_window_monitor: RTL and testbench
=====================================

# ber_window_monitor

Windowed bit-error-rate measurement stage directly downstream of the 64-bit alignment/PRBS7-check stage. Consumes the per-word bit-error count and the alignment flag, runs a software-triggered measurement window of programmable length over aligned words only, and holds the statistics until the next start. Provides start/abort/done control for a slow-control or ILA readout path.

## Interface
- WIN_W, 32, width of window length and word counters
- ACC_W, 40, width of the total bit-error accumulator
- SETTLE, 16, consecutive aligned cycles required before measuring (0 = measure immediately)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  single-cycle request to begin a window
- abort  in  1  terminate current window
- win_len  in  WIN_W  aligned words per window, sampled at accepted start
- aligned  in  1  alignment status from the upstream stage
- err_cnt  in  7  bit errors in the current 64-bit word (0..64)
- busy  out  1  window in progress (WAIT_LOCK or MEASURE)
- done  out  1  window complete, level until next accepted start
- aborted  out  1  last window was aborted, level until next accepted start
- words_counted  out  WIN_W  aligned words measured
- bit_err_total  out  ACC_W  sum of err_cnt, saturating
- err_words  out  WIN_W  words with err_cnt != 0
- max_burst  out  7  largest err_cnt seen
- first_err_idx  out  WIN_W  index of first errored word; all-ones = none
- unlock_events  out  8  aligned 1->0 transitions during MEASURE, saturating at 255
- lock_lost  out  1  at least one unlock event in window

## Operation
- States: IDLE, WAIT_LOCK, MEASURE, DONE. Reset -> IDLE.
- start accepted only in IDLE or DONE; ignored in WAIT_LOCK/MEASURE. On acceptance: latch win_len (0 treated as 1), clear all statistics, first_err_idx <= all-ones, done/aborted <= 0, go WAIT_LOCK (or MEASURE if SETTLE=0).
- WAIT_LOCK: settle counter increments on aligned=1, clears on aligned=0; on the cycle it reaches SETTLE, next state MEASURE. No statistics accumulate.
- MEASURE, each cycle with aligned=1: first_err_idx <= words_counted if err_cnt!=0 and first_err_idx is all-ones; words_counted += 1; bit_err_total += err_cnt (saturate at 2^ACC_W-1); err_words += 1 if err_cnt!=0; max_burst <= max(max_burst, err_cnt). Cycles with aligned=0 are skipped entirely (err_cnt ignored).
- MEASURE: aligned previous=1, current=0 -> unlock_events += 1 (saturating), lock_lost <= 1; remain in MEASURE. Previous-aligned register initialised to 1 on MEASURE entry.
- Cycle that counts word number win_len -> next state DONE.
- abort in WAIT_LOCK or MEASURE -> IDLE, aborted <= 1, statistics frozen at current values. abort in IDLE/DONE ignored. abort and start in the same cycle: abort wins, start dropped.

## Timing
- Reset values: busy 0, done 0, aborted 0, words_counted 0, bit_err_total 0, err_words 0, max_burst 0, first_err_idx all-ones, unlock_events 0, lock_lost 0.
- All outputs registered; err_cnt/aligned used directly (already registered upstream).
- start at edge T -> busy=1 and statistics cleared at T+1.
- Word counted at edge T is reflected in outputs at T+1; the final word and done=1, busy=0 appear together at T+1.
- Minimum window with SETTLE=16, aligned steady, win_len=N: done rises 17+N cycles after start edge.
- reset mid-window: immediate return to reset values, no done/aborted.
- Counters other than bit_err_total/unlock_events never exceed win_len, so no wrap.

## Test plan
- SETTLE=16, aligned=1, err_cnt=0, win_len=100, start -> done at start+117, words_counted=100, bit_err_total=0, err_words=0, first_err_idx=all-ones.
- win_len=10, err_cnt=3 on words 4 and 7, 64 on word 9 -> bit_err_total=70, err_words=3, max_burst=64, first_err_idx=4.
- aligned drops for 5 cycles twice mid-window, win_len=50 -> words_counted=50, unlock_events=2, lock_lost=1, done delayed by 10 cycles.
- abort at word 20 of win_len=100; start+abort same cycle afterwards -> aborted=1, done=0, words_counted=20, second start ignored, state IDLE.
- ACC_W=8, err_cnt=64 for 10 words -> bit_err_total=255 (saturated); reset during MEASURE -> all reset values next cycle; start while busy ignored.

Source files
------------

// File: rtl/ber_window_monitor.sv
// rtl/ber_window_monitor.sv - windowed bit-error-rate statistics over aligned 64-bit words
module ber_window_monitor #(
    parameter int WIN_W  = 32,
    parameter int ACC_W  = 40,
    parameter int SETTLE = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [WIN_W-1:0] i_win_len,
    input  logic             i_aligned,
    input  logic [6:0]       i_err_cnt,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_aborted,
    output logic [WIN_W-1:0] o_words_counted,
    output logic [ACC_W-1:0] o_bit_err_total,
    output logic [WIN_W-1:0] o_err_words,
    output logic [6:0]       o_max_burst,
    output logic [WIN_W-1:0] o_first_err_idx,
    output logic [7:0]       o_unlock_events,
    output logic             o_lock_lost
);

    localparam int SET_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [SET_W-1:0] SETTLE_V = SET_W'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_MEASURE   = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIN_W-1:0]   r_win_len;
    logic [SET_W-1:0]   r_settle;
    logic               r_prev_al;
    logic               r_busy;
    logic               r_done;
    logic               r_aborted;
    logic [WIN_W-1:0]   r_words;
    logic [ACC_W-1:0]   r_total;
    logic [WIN_W-1:0]   r_err_words;
    logic [6:0]         r_max;
    logic [WIN_W-1:0]   r_first;
    logic [7:0]         r_unl;
    logic               r_lost;

    logic               w_start_ok;
    logic               w_abort_ok;
    logic               w_word;
    logic               w_last_word;
    logic [WIN_W-1:0]   w_words_inc;
    logic [ACC_W:0]     w_sum;

    // abort always beats start; start is only honoured when no window is running
    assign w_start_ok  = i_start && !i_abort && (r_state == S_IDLE || r_state == S_DONE);
    assign w_abort_ok  = i_abort && (r_state == S_WAIT_LOCK || r_state == S_MEASURE);
    assign w_word      = (r_state == S_MEASURE) && i_aligned && !i_abort;
    assign w_words_inc = r_words + WIN_W'(1);
    assign w_last_word = w_word && (w_words_inc == r_win_len);
    assign w_sum       = {1'b0, r_total} + (ACC_W+1)'(i_err_cnt);

    // state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // next-state logic: settle wait, word counting, abort
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_ok) w_next = (SETTLE == 0) ? S_MEASURE : S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (i_abort)                  w_next = S_IDLE;
                else if (r_settle == SETTLE_V) w_next = S_MEASURE;
            end
            S_MEASURE: begin
                if (i_abort)          w_next = S_IDLE;
                else if (w_last_word) w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // registered status flags derived from the upcoming state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next == S_WAIT_LOCK) || (w_next == S_MEASURE);
            r_done <= (w_next == S_DONE);
        end
    end

    // window statistics, settle counter and unlock detection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_win_len   <= WIN_W'(1);
            r_settle    <= '0;
            r_prev_al   <= 1'b1;
            r_aborted   <= 1'b0;
            r_words     <= '0;
            r_total     <= '0;
            r_err_words <= '0;
            r_max       <= '0;
            r_first     <= '1;
            r_unl       <= '0;
            r_lost      <= 1'b0;
        end else if (w_start_ok) begin
            r_win_len   <= (i_win_len == '0) ? WIN_W'(1) : i_win_len;
            r_settle    <= '0;
            r_prev_al   <= 1'b1;
            r_aborted   <= 1'b0;
            r_words     <= '0;
            r_total     <= '0;
            r_err_words <= '0;
            r_max       <= '0;
            r_first     <= '1;
            r_unl       <= '0;
            r_lost      <= 1'b0;
        end else begin
            if (w_abort_ok) r_aborted <= 1'b1;

            if (r_state == S_WAIT_LOCK && !i_abort && r_settle != SETTLE_V)
                r_settle <= i_aligned ? r_settle + 1'b1 : '0;

            // previous-aligned sits at 1 outside MEASURE so entry starts clean
            if (r_state != S_MEASURE) begin
                r_prev_al <= 1'b1;
            end else if (!i_abort) begin
                r_prev_al <= i_aligned;
                if (r_prev_al && !i_aligned) begin
                    if (r_unl != 8'hFF) r_unl <= r_unl + 8'd1;
                    r_lost <= 1'b1;
                end
            end

            if (w_word) begin
                if (i_err_cnt != 7'd0 && r_first == '1) r_first <= r_words;
                r_words <= w_words_inc;
                r_total <= w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
                if (i_err_cnt != 7'd0) r_err_words <= r_err_words + WIN_W'(1);
                if (i_err_cnt > r_max) r_max <= i_err_cnt;
            end
        end
    end

    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_aborted       = r_aborted;
    assign o_words_counted = r_words;
    assign o_bit_err_total = r_total;
    assign o_err_words     = r_err_words;
    assign o_max_burst     = r_max;
    assign o_first_err_idx = r_first;
    assign o_unlock_events = r_unl;
    assign o_lock_lost     = r_lost;

endmodule

// File: tb/tb_ber_window_monitor.sv
// tb/tb_ber_window_monitor.sv - scoreboard bench for ber_window_monitor
module tb_ber_window_monitor;

    localparam int WIN_W  = 32;
    localparam int ACC_W  = 8;
    localparam int SETTLE = 16;
    localparam int MAXC   = 1000;
    localparam logic [31:0] NONE = 32'hFFFF_FFFF;

    logic             clk = 1'b0;
    logic             reset;
    logic             i_start;
    logic             i_abort;
    logic [WIN_W-1:0] i_win_len;
    logic             i_aligned;
    logic [6:0]       i_err_cnt;
    logic             o_busy;
    logic             o_done;
    logic             o_aborted;
    logic [WIN_W-1:0] o_words_counted;
    logic [ACC_W-1:0] o_bit_err_total;
    logic [WIN_W-1:0] o_err_words;
    logic [6:0]       o_max_burst;
    logic [WIN_W-1:0] o_first_err_idx;
    logic [7:0]       o_unlock_events;
    logic             o_lock_lost;

    ber_window_monitor #(.WIN_W(WIN_W), .ACC_W(ACC_W), .SETTLE(SETTLE)) dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_abort(i_abort),
        .i_win_len(i_win_len), .i_aligned(i_aligned), .i_err_cnt(i_err_cnt),
        .o_busy(o_busy), .o_done(o_done), .o_aborted(o_aborted),
        .o_words_counted(o_words_counted), .o_bit_err_total(o_bit_err_total),
        .o_err_words(o_err_words), .o_max_burst(o_max_burst),
        .o_first_err_idx(o_first_err_idx), .o_unlock_events(o_unlock_events),
        .o_lock_lost(o_lock_lost)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] words;
        logic [7:0]  total;
        logic [31:0] errw;
        logic [6:0]  maxb;
        logic [31:0] first;
        logic [7:0]  unl;
        logic        lost;
        logic        ab;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int pass_cnt = 0;
    int total_cnt = 0;

    bit al [MAXC];
    int er [MAXC];
    bit st [MAXC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"},  o_busy, 0);
        chk({tag, "_done"},  o_done, 0);
        chk({tag, "_abrt"},  o_aborted, 0);
        chk({tag, "_words"}, o_words_counted, 0);
        chk({tag, "_total"}, o_bit_err_total, 0);
        chk({tag, "_errw"},  o_err_words, 0);
        chk({tag, "_maxb"},  o_max_burst, 0);
        chk({tag, "_first"}, o_first_err_idx, NONE);
        chk({tag, "_unl"},   o_unlock_events, 0);
        chk({tag, "_lost"},  o_lock_lost, 0);
    endtask

    // Monitor: any rising done/aborted is a completed window; compare with the oldest expectation
    bit prev_done = 0, prev_ab = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset && ((o_done && !prev_done) || (o_aborted && !prev_ab))) begin
            if (q.size() == 0) begin
                chk("unexpected_completion", 1, 0);
            end else begin
                e = q.pop_front();
                chk("end_cycle",  cyc, e.cyc);
                chk("done_flag",  o_done, !e.ab);
                chk("abort_flag", o_aborted, e.ab);
                chk("words",      o_words_counted, e.words);
                chk("bit_total",  o_bit_err_total, e.total);
                chk("err_words",  o_err_words, e.errw);
                chk("max_burst",  o_max_burst, e.maxb);
                chk("first_idx",  o_first_err_idx, e.first);
                chk("unlocks",    o_unlock_events, e.unl);
                chk("lock_lost",  o_lock_lost, e.lost);
            end
        end
        prev_done = o_done;
        prev_ab   = o_aborted;
    end

    // Reference model. Cycle c is the c-th clock after the start edge. Measuring begins the
    // cycle after the first point where the SETTLE preceding cycles were all aligned.
    function automatic exp_t model(input int len_in, input int ab_at, input int sc);
        exp_t e;
        int len = (len_in == 0) ? 1 : len_in;
        int m = MAXC;
        int tot = 0;
        bit prev = 1;
        bit ok;
        e.words = 0; e.total = 0; e.errw = 0; e.maxb = 0; e.first = NONE;
        e.unl = 0; e.lost = 0; e.ab = 0; e.cyc = -1;
        for (int c = SETTLE; c < MAXC; c++) begin
            ok = 1;
            for (int k = c - SETTLE; k < c; k++) if (!al[k]) ok = 0;
            if (ok) begin m = c + 1; break; end
        end
        for (int c = 0; c < MAXC; c++) begin
            if (c == ab_at) begin e.ab = 1; e.cyc = sc + 1 + c; break; end
            if (c >= m) begin
                if (al[c]) begin
                    if (er[c] != 0 && e.first == NONE) e.first = e.words;
                    e.words++;
                    tot += er[c];
                    if (er[c] != 0) e.errw++;
                    if (er[c] > int'(e.maxb)) e.maxb = 7'(er[c]);
                    if (int'(e.words) == len) begin e.cyc = sc + 1 + c; end
                end else if (prev) begin
                    if (e.unl != 8'hFF) e.unl++;
                    e.lost = 1;
                end
                prev = al[c];
                if (e.cyc >= 0) break;
            end
        end
        e.total = (tot > 255) ? 8'hFF : 8'(tot);
        return e;
    endfunction

    task automatic fill_default();
        for (int c = 0; c < MAXC; c++) begin al[c] = 1; er[c] = 0; st[c] = 0; end
    endtask

    // Issue one window: push expectation, assert start, then replay the per-cycle stimulus
    task automatic run_window(input int len, input int ab_at, input bit use_model, input exp_t given);
        exp_t e;
        int sc;
        bit ended = 0;
        @(negedge clk);
        sc = cyc + 1;
        if (use_model) e = model(len, ab_at, sc);
        else begin e = given; e.cyc = sc + given.cyc; end
        q.push_back(e);
        i_start = 1; i_win_len = len;
        @(posedge clk); @(negedge clk);
        i_start = 0;
        chk("busy_after_start", o_busy, 1);
        chk("words_cleared", o_words_counted, 0);
        for (int c = 0; c < MAXC; c++) begin
            i_aligned = al[c];
            i_err_cnt = 7'(er[c]);
            i_abort   = (c == ab_at);
            i_start   = st[c];
            i_win_len = st[c] ? 5 : len;
            @(posedge clk); @(negedge clk);
            i_abort = 0; i_start = 0;
            if (o_done || o_aborted) begin ended = 1; break; end
        end
        i_aligned = 1; i_err_cnt = 0;
        if (!ended) begin
            chk("window_timeout", 0, 1);
            reset = 1; @(posedge clk); @(negedge clk); reset = 0;
            void'(q.pop_back());
        end
    endtask

    function automatic exp_t mk(input int w, input int t, input int ew, input int mb,
                                input logic [31:0] f, input int u, input bit l, input bit a, input int off);
        exp_t e;
        e.words = w; e.total = 8'(t); e.errw = ew; e.maxb = 7'(mb); e.first = f;
        e.unl = 8'(u); e.lost = l; e.ab = a; e.cyc = off;
        return e;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        exp_t dummy;
        int len, ab;
        dummy = mk(0, 0, 0, 0, NONE, 0, 0, 0, 0);
        reset = 1; i_start = 0; i_abort = 0; i_win_len = 0; i_aligned = 1; i_err_cnt = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        reset = 0;

        // steady lock, clean link: done 117 cycles after start
        fill_default();
        run_window(100, -1, 0, mk(100, 0, 0, 0, NONE, 0, 0, 0, 117));

        // errors on words 4 and 7 (3 bits) and word 9 (64 bits); a start mid-window is ignored
        fill_default();
        er[17 + 4] = 3; er[17 + 7] = 3; er[17 + 9] = 64; st[20] = 1;
        run_window(10, -1, 0, mk(10, 70, 3, 64, 4, 0, 0, 0, 27));

        // two 5-cycle lock drops during measurement delay done by 10
        fill_default();
        for (int c = 27; c < 32; c++) al[c] = 0;
        for (int c = 47; c < 52; c++) al[c] = 0;
        run_window(50, -1, 0, mk(50, 0, 0, 0, NONE, 2, 1, 0, 77));

        // abort once 20 words are counted
        fill_default();
        run_window(100, 37, 0, mk(20, 0, 0, 0, NONE, 0, 0, 1, 38));

        // start together with abort afterwards: start dropped, stays idle
        @(negedge clk);
        i_start = 1; i_abort = 1; i_win_len = 7;
        @(posedge clk); @(negedge clk);
        i_start = 0; i_abort = 0;
        for (int k = 0; k < 3; k++) begin
            chk("sa_busy", o_busy, 0);
            chk("sa_aborted", o_aborted, 1);
            chk("sa_done", o_done, 0);
            chk("sa_words", o_words_counted, 20);
            @(negedge clk);
        end

        // accumulator saturation: 10 words of 64 errors into an 8-bit total
        fill_default();
        for (int c = 17; c < 27; c++) er[c] = 64;
        run_window(10, -1, 0, mk(10, 255, 10, 64, 0, 0, 0, 0, 27));

        // reset in the middle of a measurement
        fill_default();
        @(negedge clk);
        i_start = 1; i_win_len = 100; i_err_cnt = 5;
        @(posedge clk); @(negedge clk);
        i_start = 0;
        repeat (30) @(negedge clk);
        chk("mid_busy", o_busy, 1);
        reset = 1;
        @(posedge clk); @(negedge clk);
        reset = 0; i_err_cnt = 0;
        check_reset_vals("midrst");

        // zero window length behaves as one word
        fill_default();
        er[17] = 9;
        run_window(0, -1, 1, dummy);

        // randomized windows against the reference model
        for (int n = 0; n < 10; n++) begin
            for (int c = 0; c < MAXC; c++) begin
                al[c] = (c < 8) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 19) != 0);
                er[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 64)) : 0;
                st[c] = (c == 3);
            end
            len = $urandom_range(1, 80);
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 70)) : -1;
            run_window(len, ab, 1, dummy);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
